// File: rtl/icache_arbiter.sv
// icache_arbiter: two-requester arbiter in front of a single-outstanding instruction cache port.
//
// Requester 0 is the fetch path and requester 1 is the prefetch path. In IDLE one request is
// granted combinationally, and its address and owner id are registered. The block then waits in
// BUSY for cache_instruction_valid and returns the word to the owner. A flush drops the request
// in flight. Any late cache response then drains in DRAIN. A wait counter aborts a request that
// is never answered and pulses timeout_err.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum wait cycles in BUSY/DRAIN before the request is aborted
//   ADDR_W          instruction address width
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   flush                      redirect; cancels the outstanding request
//   req0_valid/addr            fetch request
//   req1_valid/addr            prefetch request
//   req0_grant, req1_grant     request accepted this cycle
//   rsp0_valid, rsp1_valid     response returned to that requester
//   rsp_data                   instruction word (shared, always cache_instruction_data)
//   cache_instruction_addr     registered address presented to the icache
//   cache_instruction_data     instruction word from the icache
//   cache_instruction_valid    icache data valid
//   timeout_err                one-cycle pulse on timeout abort
//
// Configuration macro:
//   ICACHE_ARB_RR_EN  defined: round-robin arbitration on ties; undefined: requester 0 wins ties.

module icache_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req0_grant,
    output logic              req1_grant,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [31:0]       rsp_data,
    output logic [ADDR_W-1:0] cache_instruction_addr,
    input  logic [31:0]       cache_instruction_data,
    input  logic              cache_instruction_valid,
    output logic              timeout_err
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              owner_q;
    logic              win1;
    logic              req_any;
    logic              expired;

    assign req_any = req0_valid | req1_valid;
    assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

`ifdef ICACHE_ARB_RR_EN
    // last_q = 1 means requester 1 won the previous grant, so requester 0 wins the next tie.
    logic last_q;
    assign win1 = req1_valid & (~req0_valid | ~last_q);
`else
    assign win1 = req1_valid & ~req0_valid;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and wait counter.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!flush && req_any) state_d = StBusy;
            end
            StBusy: begin
                // A response always closes the request, even when a flush discards it.
                if (cache_instruction_valid) state_d = StIdle;
                else if (flush)              state_d = StDrain;
                else if (expired)            state_d = StIdle;
            end
            StDrain: begin
                if (cache_instruction_valid || expired) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Clear on every state change (entry to BUSY/DRAIN) and while idle.
        if (state_q == StIdle || state_d != state_q) begin
            cnt_d = '0;
        end else if (!cache_instruction_valid) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs.
    always_comb begin
        req0_grant  = 1'b0;
        req1_grant  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        timeout_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Grants are combinational from the inputs, so they are gated while reset is high.
                if (!reset && !flush && req_any) begin
                    req0_grant = ~win1;
                    req1_grant = win1;
                end
            end
            StBusy: begin
                if (cache_instruction_valid && !flush) begin
                    rsp0_valid = ~owner_q;
                    rsp1_valid = owner_q;
                end
                timeout_err = !cache_instruction_valid && !flush && expired;
            end
            StDrain: begin
                timeout_err = !cache_instruction_valid && expired;
            end
            default: ;
        endcase
    end

    // Request registers; the address is held until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            owner_q <= 1'b0;
        end else if (state_q == StIdle && !flush && req_any) begin
            addr_q  <= win1 ? req1_addr : req0_addr;
            owner_q <= win1;
        end
    end

`ifdef ICACHE_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (state_q == StIdle && !flush && req_any) begin
            last_q <= win1;
        end
    end
`endif

    assign cache_instruction_addr = addr_q;
    assign rsp_data               = cache_instruction_data;

endmodule

// File: tb/tb_icache_arbiter.sv
module tb_icache_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic        req0_grant, req1_grant;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic [31:0] cache_instruction_addr;
    logic [31:0] cache_instruction_data;
    logic        cache_instruction_valid;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    icache_arbiter #(
        .TIMEOUT_CYCLES(4),
        .ADDR_W        (32)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .flush                  (flush),
        .req0_valid             (req0_valid),
        .req0_addr              (req0_addr),
        .req1_valid             (req1_valid),
        .req1_addr              (req1_addr),
        .req0_grant             (req0_grant),
        .req1_grant             (req1_grant),
        .rsp0_valid             (rsp0_valid),
        .rsp1_valid             (rsp1_valid),
        .rsp_data               (rsp_data),
        .cache_instruction_addr (cache_instruction_addr),
        .cache_instruction_data (cache_instruction_data),
        .cache_instruction_valid(cache_instruction_valid),
        .timeout_err            (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle before sampling.
    task automatic cyc(input logic r0, input logic [31:0] a0, input logic r1,
                       input logic [31:0] a1, input logic fl, input logic cv,
                       input logic [31:0] cd);
        @(negedge clk);
        req0_valid              = r0;
        req0_addr               = a0;
        req1_valid              = r1;
        req1_addr               = a1;
        flush                   = fl;
        cache_instruction_valid = cv;
        cache_instruction_data  = cd;
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_g0"}, {31'b0, req0_grant}, 32'd0);
        chk({tag, "_g1"}, {31'b0, req1_grant}, 32'd0);
        chk({tag, "_r0"}, {31'b0, rsp0_valid}, 32'd0);
        chk({tag, "_r1"}, {31'b0, rsp1_valid}, 32'd0);
    endtask

    initial begin
        logic exp_w1;
        flush = 0; req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
        cache_instruction_valid = 0; cache_instruction_data = 0;

        // Reset state: grants suppressed even with a request pending.
        #1 reset = 1'b1;
        req0_valid = 1'b1;
        #3;
        chk_idle_outs("rst");
        chk("rst_addr", cache_instruction_addr, 32'h0);
        chk("rst_tmo", {31'b0, timeout_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b0;

        // Single fetch, response three cycles after the grant.
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        chk("t29_g0", {31'b0, req0_grant}, 32'd1);
        chk("t29_g1", {31'b0, req1_grant}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk_idle_outs("t29_b1");
        chk("t29_addr1", cache_instruction_addr, 32'h100);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t29_addr2", cache_instruction_addr, 32'h100);
        chk("t29_r0_early", {31'b0, rsp0_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("t29_addr3", cache_instruction_addr, 32'h100);
        chk("t29_r0", {31'b0, rsp0_valid}, 32'd1);
        chk("t29_r1", {31'b0, rsp1_valid}, 32'd0);
        chk("t29_data", rsp_data, 32'hDEADBEEF);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t29_r0_once", {31'b0, rsp0_valid}, 32'd0);
        chk("t24_addr_hold", cache_instruction_addr, 32'h100);

        // Reset in the middle of BUSY, between clock edges; a late valid must be ignored.
        cyc(0, 0, 1, 32'h200, 0, 0, 0);
        chk("t34_g1", {31'b0, req1_grant}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t34_addr", cache_instruction_addr, 32'h200);
        #2 reset = 1'b1;
        cache_instruction_valid = 1'b1;
        cache_instruction_data  = 32'h55AA55AA;
        #1;
        chk_idle_outs("t34_inrst");
        chk("t34_addr0", cache_instruction_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle_outs("t34_late");

        // Both requesters with zero-delay cache; first tie after reset goes to requester 0.
        for (int i = 0; i < 4; i++) begin
`ifdef ICACHE_ARB_RR_EN
            exp_w1 = (i % 2) == 1;
`else
            exp_w1 = 1'b0;
`endif
            cyc(1, 32'h300, 1, 32'h400, 0, 1, 32'h11110000 + i);
            chk($sformatf("t30_g0_%0d", i), {31'b0, req0_grant}, {31'b0, ~exp_w1});
            chk($sformatf("t30_g1_%0d", i), {31'b0, req1_grant}, {31'b0, exp_w1});
            cyc(1, 32'h300, 1, 32'h400, 0, 1, 32'h22220000 + i);
            chk($sformatf("t30_r0_%0d", i), {31'b0, rsp0_valid}, {31'b0, ~exp_w1});
            chk($sformatf("t30_r1_%0d", i), {31'b0, rsp1_valid}, {31'b0, exp_w1});
            chk($sformatf("t30_a_%0d", i), cache_instruction_addr,
                exp_w1 ? 32'h400 : 32'h300);
        end

        // Flush in IDLE blocks grants.
        cyc(1, 32'h900, 1, 32'h910, 1, 0, 0);
        chk_idle_outs("t17");

        // Flush one cycle after grant, valid arrives later while draining.
        cyc(0, 0, 1, 32'h200, 0, 0, 0);
        chk("t31_g1", {31'b0, req1_grant}, 32'd1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk_idle_outs("t31_flush");
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk_idle_outs("t31_drain");
        chk("t31_addr", cache_instruction_addr, 32'h200);
        cyc(1, 32'h500, 0, 0, 0, 1, 32'hCAFEF00D);
        chk_idle_outs("t31_valid");
        cyc(1, 32'h500, 0, 0, 0, 0, 0);
        chk("t31_regrant", {31'b0, req0_grant}, 32'd1);

        // Flush and valid together in BUSY: discarded, IDLE next cycle.
        cyc(0, 0, 0, 0, 1, 1, 32'hBAD0BAD0);
        chk_idle_outs("t32");
        cyc(1, 32'h600, 0, 0, 0, 0, 0);
        chk("t32_idle_grant", {31'b0, req0_grant}, 32'd1);

        // Timeout: the grant above starts the wait; the abort pulses 4 cycles later.
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("t33_wait%0d", i), {31'b0, timeout_err}, 32'd0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t33_pulse", {31'b0, timeout_err}, 32'd1);
        chk("t33_norsp", {31'b0, rsp0_valid}, 32'd0);
        cyc(0, 0, 1, 32'h700, 0, 0, 0);
        chk("t33_once", {31'b0, timeout_err}, 32'd0);
        chk("t33_regrant", {31'b0, req1_grant}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 32'h12345678);
        chk("t33_r1", {31'b0, rsp1_valid}, 32'd1);
        chk("t33_data", rsp_data, 32'h12345678);
        chk("t33_addr", cache_instruction_addr, 32'h700);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
